snn_pool_window_scheduler: RTL
==============================

# snn_pool_window_scheduler

Window controller and input arbiter for the SNN max-pooling layer. Merges NUM_SRC spike AXI-Streams into the pool's single 48-bit input stream using round-robin arbitration. Divides time into fixed-length pooling windows; at each window boundary it stops granting, drains its output register, pulses `window_close`, and waits for the pool's `window_ack` before opening the next window. This keeps spike accumulation and output scan in the pool strictly separated.

## Interface
- NUM_SRC, 4, number of upstream spike sources (2..8)
- DATA_WIDTH, 48, spike word width: {timestamp[15:0], ch[7:0], y[7:0], x[7:0], valid[7:0]}
- clk  in  1  clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- enable  in  1  run request
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source words; source i at bits [i*48 +: 48]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit high per cycle
- s_axis_tlast  in  NUM_SRC  per-source last
- m_axis_tdata  out  DATA_WIDTH  merged word to pool, unmodified
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  pool ready
- m_axis_tlast  out  1  tlast of the granted source
- window_cycles  in  16  OPEN length in cycles; 0 is treated as 1
- window_close  out  1  one-cycle pulse: window ended, pool must scan
- window_ack  in  1  pool scan complete
- window_index  out  16  index of the current window
- spike_count  out  32  beats delivered downstream (m_axis_tvalid & m_axis_tready)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, OPEN, DRAIN, CLOSE_WAIT.
- IDLE: if `enable`=1, go to OPEN and clear the timer to 0.
- OPEN:
  - Timer increments every cycle.
  - The arbiter selects the first asserted `s_axis_tvalid` at or after `rr_ptr`, scanning upward with wrap.
  - `s_axis_tready[winner]` = (state==OPEN) & slot_free, where slot_free = !m_axis_tvalid | m_axis_tready. Combinational.
  - On an accepted beat: load the output register (tdata, tlast) and set `rr_ptr` = winner+1 mod NUM_SRC.
  - `rr_ptr` holds when no beat is accepted.
  - After exactly max(window_cycles,1) OPEN cycles, go to DRAIN. Grants remain legal in the last OPEN cycle.
  - If `enable` drops during OPEN, go to DRAIN on the next cycle (early close).
- DRAIN: no grants (all tready=0). When `m_axis_tvalid`==0, pulse `window_close` for one cycle and go to CLOSE_WAIT.
- CLOSE_WAIT:
  - No grants.
  - On `window_ack`=1: increment `window_index` (wraps 0xFFFF→0) and clear the timer.
  - Then go to OPEN if `enable`=1, else IDLE.
- `window_ack` outside CLOSE_WAIT is ignored.
- `spike_count` increments on each downstream handshake; wraps at 2^32.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, rr_ptr=0, timer=0, and every output is 0: m_axis_tdata, m_axis_tvalid, m_axis_tlast, s_axis_tready, window_close, window_index, spike_count, busy.
- Latency: source beat accepted at cycle N appears on m_axis at N+1.
- Throughput: 1 beat/cycle while m_axis_tready=1.
- Backpressure:
  - m_axis_tvalid/tdata/tlast stay stable while m_axis_tready=0.
  - No source is granted while the output register is full and not draining.
- window_close asserts the cycle after the DRAIN cycle in which m_axis_tvalid is seen 0. If the register is already empty on DRAIN entry, the gap from the last OPEN cycle to window_close is 1 cycle.
- Reset mid-window aborts immediately. In-flight word is lost. Window index returns to 0.

## Test plan
- Round-robin: NUM_SRC=4, all valid continuously, window_cycles=100, m_tready=1 → grant order 0,1,2,3,0,…; 100 beats per window; spike_count=100 at window_close.
- Backpressure: m_tready held 0 for 5 cycles with tvalid=1 → m_axis_tdata stable; all s_axis_tready=0 after the register fills; no beat lost or duplicated (compare scoreboard).
- Window boundary: window_cycles=10, single source streaming, ack returned 3 cycles after close → exactly 10 OPEN cycles; window_close is 1 cycle wide; no tready during DRAIN/CLOSE_WAIT; window_index 0→1 on ack.
- window_cycles=0 → OPEN lasts 1 cycle; at most 1 beat per window.
- Early close: enable dropped mid-OPEN → DRAIN, close pulse, ack → IDLE; busy=0.
- Async reset mid-DRAIN with m_tvalid=1 → all outputs 0 immediately; after release with enable=1, window_index=0 and arbitration restarts at source 0.

Source files
------------

// File: rtl/snn_pool_window_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snn_pool_window_scheduler: round-robin spike-stream merger with pooling    |
// | window sequencing (OPEN -> DRAIN -> close pulse -> wait for pool ack).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snn_pool_window_scheduler #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 48
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [15:0]                   window_cycles,
  output logic                          window_close,
  input  logic                          window_ack,
  output logic [15:0]                   window_index,
  output logic [31:0]                   spike_count,
  output logic                          busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PW:0]   c_NSRC = (PW+1)'(NUM_SRC);
  localparam logic [PW-1:0] c_LAST = PW'(NUM_SRC - 1);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_OPEN       = 2'd1;
  localparam logic [1:0] c_DRAIN      = 2'd2;
  localparam logic [1:0] c_CLOSE_WAIT = 2'd3;

  logic [1:0]            r_state;
  logic [15:0]           r_timer;
  logic [PW-1:0]         r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_window_close;
  logic [15:0]           r_window_index;
  logic [31:0]           r_spike_count;

  logic [15:0]           w_timer_last;
  logic                  w_slot_free;
  logic                  w_found;
  logic [PW-1:0]         w_winner;
  logic [PW:0]           w_idx;
  logic                  w_grant;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

  // A programmed length of 0 still yields one OPEN cycle.
  assign w_timer_last = (window_cycles == 16'd0) ? 16'd0 : window_cycles - 16'd1;
  assign w_slot_free  = !r_tvalid || m_axis_tready;
  assign w_grant      = (r_state == c_OPEN) && w_slot_free && w_found;

  // First requesting source at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= c_NSRC) w_idx = w_idx - c_NSRC;
      if (!w_found && s_axis_tvalid[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    w_sel_data    = '0;
    w_sel_last    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_winner == PW'(i)) begin
        s_axis_tready[i] = w_grant;
        w_sel_data       = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last       = s_axis_tlast[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_IDLE;
      r_timer        <= '0;
      r_rr_ptr       <= '0;
      r_tdata        <= '0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_window_close <= 1'b0;
      r_window_index <= '0;
      r_spike_count  <= '0;
    end else begin
      r_window_close <= 1'b0;

      if (r_tvalid && m_axis_tready) r_spike_count <= r_spike_count + 32'd1;

      if (w_grant) begin
        r_tdata  <= w_sel_data;
        r_tlast  <= w_sel_last;
        r_tvalid <= 1'b1;
        r_rr_ptr <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        c_IDLE: begin
          if (enable) begin
            r_state <= c_OPEN;
            r_timer <= '0;
          end
        end
        c_OPEN: begin
          r_timer <= r_timer + 16'd1;
          if (!enable || (r_timer == w_timer_last)) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          // Close only once the last granted word has left the register.
          if (!r_tvalid) begin
            r_window_close <= 1'b1;
            r_state        <= c_CLOSE_WAIT;
          end
        end
        c_CLOSE_WAIT: begin
          if (window_ack) begin
            r_window_index <= r_window_index + 16'd1;
            r_timer        <= '0;
            r_state        <= enable ? c_OPEN : c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign window_close  = r_window_close;
  assign window_index  = r_window_index;
  assign spike_count   = r_spike_count;
  assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire
